mpu_bus_master: RTL and testbench
=================================

Name: mpu_bus_master

Overview:
- Host-side initiator for the VGA controller's 8-bit MPU register port.
- Converts valid/ready register commands (read or write, 3-bit register select, 8-bit data) into timed chip-select, write-enable, register-select and data-bus cycles.
- Drives the same pins the VGA register responder samples.
- Used by the bench/host-emulation path and by any on-chip sequencer that programs the video controller.

Parameters:
SETUP_CYCLES, 1, cycles that register select/write data are stable before the strobe (1..15)
STROBE_CYCLES, 2, cycles chip select is asserted (1..15)
HOLD_CYCLES, 1, cycles that address/write data are held after the strobe (1..15)
RECOVER_CYCLES, 1, idle cycles with the bus released before the next command (1..15)

Ports:
clock  input  1  system clock, all state on rising edge
resetN  input  1  asynchronous active-low reset
cmdValid  input  1  command present
cmdReady  output  1  command accepted when cmdValid && cmdReady at clock edge
cmdWrite  input  1  1 = register write, 0 = register read
cmdRegister  input  3  target register select
cmdData  input  8  write data (ignored for reads)
rspValid  output  1  one-cycle pulse: transaction complete
rspData  output  8  read data captured for the completed read; 0 for writes
busy  output  1  high whenever state != IDLE
mpuChipSelect  output  1  active-low chip select
mpuWriteEnable  output  1  active-low; low = write cycle
mpuRegisterSelect  output  3  register select to responder
mpuData  inout  8  bidirectional data bus, driven only during write transactions

Behaviour:
- Reset is asynchronous and active-low; it applies immediately, including mid-transaction. Reset values:
  - state IDLE, cmdReady=1, busy=0, rspValid=0, rspData=0.
  - mpuChipSelect=1, mpuWriteEnable=1, mpuRegisterSelect=0, mpuData=Z, all counters 0.
- All bus outputs are registered; no combinational path from cmd* to mpu* pins.
- FSM states, transitions and pin behaviour:
  - IDLE: cmdReady=1. On cmdValid&&cmdReady, latch cmdWrite/cmdRegister/cmdData and go to SETUP.
  - SETUP: mpuRegisterSelect=latched register, CS=1. Write: mpuData driven with latched data, WE=0. Read: mpuData=Z, WE=1. Stay SETUP_CYCLES cycles, then STROBE.
  - STROBE: CS=0, other signals unchanged. Stay STROBE_CYCLES cycles. For reads, mpuData is sampled into the capture register at the clock edge ending the last STROBE cycle. Then HOLD.
  - HOLD: CS=1, register select and write data held, WE held. rspValid pulses high in the first HOLD cycle only, with rspData = captured byte (read) or 0 (write). Stay HOLD_CYCLES cycles, then RECOVER.
  - RECOVER: mpuData=Z, WE=1, CS=1, mpuRegisterSelect keeps its last value. Stay RECOVER_CYCLES cycles, then IDLE.
- cmdReady is 0 in every state except IDLE. cmd* inputs are ignored while not ready; the upstream source holds them stable (valid/ready rule).
- Data bus is never driven during read transactions, reset or RECOVER. This guarantees no contention with the responder.
- Dwell counter: 4 bits, loaded with N-1 on state entry, decremented each cycle; state advances when it reaches 0.
- Latency with defaults (accept edge = cycle 0): SETUP cycle 1, STROBE cycles 2-3, HOLD cycle 4 (rspValid), RECOVER cycle 5, cmdReady=1 in cycle 6. Total 6 cycles per transaction.
- A command presented in the same cycle cmdReady returns is accepted in that cycle. There is no extra idle gap beyond RECOVER.
- rspData holds its value until the next rspValid pulse.
- Reset asserted mid-STROBE aborts the transaction: no rspValid, pins go inactive immediately. After release, state is IDLE and cmdReady=1.

Test Plan:
- Reset release, then write reg 3 = 0xA5 (defaults) -> cmdReady low cycles 1-5. mpuRegisterSelect=3 and mpuData=0xA5 cycles 1-4. WE low cycles 1-4. CS low exactly cycles 2-3. rspValid pulse cycle 4 with rspData=0x00. mpuData=Z from cycle 5.
- Read reg 5, responder drives 0x3C during strobe -> mpuData never driven by master. Sampled at end of cycle 3. rspValid cycle 4 with rspData=0x3C, held afterwards.
- Back-to-back: write reg 0=0x11, then read reg 1 (cmdValid held high) -> second command accepted in cycle 6. Its CS low cycles 8-9. Exactly two rspValid pulses, cycles 4 and 10.
- resetN pulled low in cycle 2 (mid-STROBE) of a write -> CS/WE go high and mpuData=Z asynchronously. No rspValid. After release, cmdReady=1 and a new command completes normally.
- STROBE_CYCLES=4, SETUP_CYCLES=3 -> CS low exactly 4 consecutive cycles, starting 3 cycles after accept. Read data sampled at end of the 4th strobe cycle.
- cmdValid toggling while busy with varying cmd* values -> ignored. Bus pins reflect only the latched command. busy=1 throughout.

Source files
------------

// File: rtl/mpu_bus_master.sv
// Host-side initiator for the VGA controller's 8-bit MPU register port.
// Turns valid/ready register commands into timed CS/WE/register-select/data bus cycles.
module mpu_bus_master #(
   parameter int unsigned SETUP_CYCLES   = 1,
   parameter int unsigned STROBE_CYCLES  = 2,
   parameter int unsigned HOLD_CYCLES    = 1,
   parameter int unsigned RECOVER_CYCLES = 1
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       cmdValid,
   output logic       cmdReady,
   input  logic       cmdWrite,
   input  logic [2:0] cmdRegister,
   input  logic [7:0] cmdData,
   output logic       rspValid,
   output logic [7:0] rspData,
   output logic       busy,
   output logic       mpuChipSelect,
   output logic       mpuWriteEnable,
   output logic [2:0] mpuRegisterSelect,
   inout  wire  [7:0] mpuData
);

   localparam logic [3:0] CntSetup   = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] CntStrobe  = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] CntHold    = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] CntRecover = 4'(RECOVER_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRecover} state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wr_q, wr_d;
   logic [2:0] reg_q, reg_d;
   logic [7:0] data_q, data_d;
   logic       cs_q, cs_d;
   logic       we_q, we_d;
   logic       oe_q, oe_d;
   logic [2:0] rs_q, rs_d;
   logic [7:0] dout_q, dout_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         reg_q       <= 3'd0;
         data_q      <= 8'd0;
         cs_q        <= 1'b1;
         we_q        <= 1'b1;
         oe_q        <= 1'b0;
         rs_q        <= 3'd0;
         dout_q      <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
         rs_q        <= rs_d;
         dout_q      <= dout_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      reg_d   = reg_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (cmdValid) begin
               wr_d    = cmdWrite;
               reg_d   = cmdRegister;
               data_d  = cmdData;
               state_d = StSetup;
               cnt_d   = CntSetup;
            end
         end
         StSetup: begin
            if (cnt_q == 4'd0) begin
               state_d = StStrobe;
               cnt_d   = CntStrobe;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StStrobe: begin
            if (cnt_q == 4'd0) begin
               state_d = StHold;
               cnt_d   = CntHold;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            if (cnt_q == 4'd0) begin
               state_d = StRecover;
               cnt_d   = CntRecover;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRecover: begin
            if (cnt_q == 4'd0) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Pins are registered from the next state so each one changes on the edge entering its phase.
   always_comb begin
      cs_d        = 1'b1;
      we_d        = 1'b1;
      oe_d        = 1'b0;
      rs_d        = rs_q;
      dout_d      = dout_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      if (state_d == StSetup || state_d == StStrobe || state_d == StHold) begin
         cs_d   = (state_d != StStrobe);
         we_d   = ~wr_d;
         oe_d   = wr_d;
         rs_d   = reg_d;
         dout_d = data_d;
      end
      // Read data is captured on the edge that ends the last strobe cycle.
      if (state_q == StStrobe && state_d == StHold) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = wr_q ? 8'd0 : mpuData;
      end
   end

   assign cmdReady          = (state_q == StIdle);
   assign busy              = (state_q != StIdle);
   assign rspValid          = rsp_valid_q;
   assign rspData           = rsp_data_q;
   assign mpuChipSelect     = cs_q;
   assign mpuWriteEnable    = we_q;
   assign mpuRegisterSelect = rs_q;
   assign mpuData           = oe_q ? dout_q : 8'bz;

endmodule

// File: tb/tb_mpu_bus_master.sv
// Randomised bench for mpu_bus_master: two instances (default and stretched timing) checked
// cycle by cycle against a phase-window model of a bus transaction.
module tb_mpu_bus_master;

   localparam int unsigned SA = 1, TA = 2, HA = 1, RA = 1;
   localparam int unsigned SB = 3, TB = 4, HB = 2, RB = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_write;
   logic [2:0] cmd_reg;
   logic [7:0] cmd_data;
   logic       sel;
   logic [7:0] resp_byte;

   wire        ready_a, rv_a, busy_a, cs_a, we_a;
   wire  [2:0] rs_a;
   wire  [7:0] rd_a;
   tri1  [7:0] bus_a;
   wire        ready_b, rv_b, busy_b, cs_b, we_b;
   wire  [2:0] rs_b;
   wire  [7:0] rd_b;
   tri1  [7:0] bus_b;

   wire        o_ready = sel ? ready_b : ready_a;
   wire        o_busy  = sel ? busy_b : busy_a;
   wire        o_rv    = sel ? rv_b : rv_a;
   wire  [7:0] o_rd    = sel ? rd_b : rd_a;
   wire        o_cs    = sel ? cs_b : cs_a;
   wire        o_we    = sel ? we_b : we_a;
   wire  [2:0] o_rs    = sel ? rs_b : rs_a;
   wire  [7:0] o_bus   = sel ? bus_b : bus_a;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_rsp_a, exp_rsp_b;

   always #5 clk = ~clk;

   // Responder: drives the read byte while a read strobe is on its bus; pull-ups show release.
   assign bus_a = (!cs_a && we_a) ? resp_byte : 8'bz;
   assign bus_b = (!cs_b && we_b) ? resp_byte : 8'bz;

   mpu_bus_master u_dut_a (
      .clock(clk), .resetN(rst_n), .cmdValid(cmd_valid && !sel), .cmdReady(ready_a),
      .cmdWrite(cmd_write), .cmdRegister(cmd_reg), .cmdData(cmd_data), .rspValid(rv_a),
      .rspData(rd_a), .busy(busy_a), .mpuChipSelect(cs_a), .mpuWriteEnable(we_a),
      .mpuRegisterSelect(rs_a), .mpuData(bus_a)
   );

   mpu_bus_master #(
      .SETUP_CYCLES(SB), .STROBE_CYCLES(TB), .HOLD_CYCLES(HB), .RECOVER_CYCLES(RB)
   ) u_dut_b (
      .clock(clk), .resetN(rst_n), .cmdValid(cmd_valid && sel), .cmdReady(ready_b),
      .cmdWrite(cmd_write), .cmdRegister(cmd_reg), .cmdData(cmd_data), .rspValid(rv_b),
      .rspData(rd_b), .busy(busy_b), .mpuChipSelect(cs_b), .mpuWriteEnable(we_b),
      .mpuRegisterSelect(rs_b), .mpuData(bus_b)
   );

   // Present a command in an idle cycle (cycle 0 of the transaction).
   task automatic start(input bit s, input bit wr, input logic [2:0] rg, input logic [7:0] dt);
      sel = s;
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready inst %0d got %b want 1", s, o_ready);
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_reg   = rg;
      cmd_data  = dt;
   endtask

   // Follow one accepted transaction from cycle 1 to the cycle cmdReady returns.
   task automatic do_txn(input string tag, input bit wr, input logic [2:0] rg,
                         input logic [7:0] dt, input logic [7:0] rb, input bit noise,
                         input bit chain, input bit nwr, input logic [2:0] nrg,
                         input logic [7:0] ndt);
      int s, t, h, tot;
      logic [7:0] prev, fin;
      s    = sel ? SB : SA;
      t    = sel ? TB : TA;
      h    = sel ? HB : HA;
      tot  = s + t + h + (sel ? RB : RA);
      prev = sel ? exp_rsp_b : exp_rsp_a;
      fin  = wr ? 8'h00 : rb;
      resp_byte = rb;
      for (int k = 1; k <= tot + 1; k++) begin
         logic e_ready, e_strobe, e_act, e_rv;
         logic [7:0] e_bus, e_rd;
         @(negedge clk);
         e_ready  = (k > tot);
         e_strobe = (k > s) && (k <= s + t);
         e_act    = (k <= s + t + h);
         e_rv     = (k == s + t + 1);
         e_bus    = (wr && e_act) ? dt : ((!wr && e_strobe) ? rb : 8'hFF);
         e_rd     = (k > s + t) ? fin : prev;
         checks += 8;
         if (o_ready !== e_ready) begin
            errors++;
            $display("FAIL %s k=%0d ready got %b want %b", tag, k, o_ready, e_ready);
         end
         if (o_busy !== !e_ready) begin
            errors++;
            $display("FAIL %s k=%0d busy got %b want %b", tag, k, o_busy, !e_ready);
         end
         if (o_cs !== !e_strobe) begin
            errors++;
            $display("FAIL %s k=%0d cs got %b want %b", tag, k, o_cs, !e_strobe);
         end
         if (o_we !== !(wr && e_act)) begin
            errors++;
            $display("FAIL %s k=%0d we got %b want %b", tag, k, o_we, !(wr && e_act));
         end
         if (o_rs !== rg) begin
            errors++;
            $display("FAIL %s k=%0d regsel got %0d want %0d", tag, k, o_rs, rg);
         end
         if (o_bus !== e_bus) begin
            errors++;
            $display("FAIL %s k=%0d bus got %h want %h", tag, k, o_bus, e_bus);
         end
         if (o_rv !== e_rv) begin
            errors++;
            $display("FAIL %s k=%0d rspValid got %b want %b", tag, k, o_rv, e_rv);
         end
         if (o_rd !== e_rd) begin
            errors++;
            $display("FAIL %s k=%0d rspData got %h want %h", tag, k, o_rd, e_rd);
         end
         if (k < tot) begin
            if (noise) begin
               cmd_valid = 1'($urandom_range(1, 0));
               cmd_write = 1'($urandom_range(1, 0));
               cmd_reg   = 3'($urandom_range(7, 0));
               cmd_data  = 8'($urandom_range(255, 0));
            end else begin
               cmd_valid = 1'b0;
            end
         end else if (k == tot) begin
            cmd_valid = chain;
            cmd_write = nwr;
            cmd_reg   = nrg;
            cmd_data  = ndt;
         end
      end
      if (sel) exp_rsp_b = fin;
      else exp_rsp_a = fin;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      sel   = 1'b0;
      repeat (3) @(negedge clk);
      checks += 8;
      if (o_ready !== 1'b1) begin errors++; $display("FAIL reset ready got %b want 1", o_ready); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", o_busy); end
      if (o_rv !== 1'b0) begin errors++; $display("FAIL reset rspValid got %b want 0", o_rv); end
      if (o_rd !== 8'h00) begin errors++; $display("FAIL reset rspData got %h want 00", o_rd); end
      if (o_cs !== 1'b1) begin errors++; $display("FAIL reset cs got %b want 1", o_cs); end
      if (o_we !== 1'b1) begin errors++; $display("FAIL reset we got %b want 1", o_we); end
      if (o_rs !== 3'd0) begin errors++; $display("FAIL reset regsel got %0d want 0", o_rs); end
      if (o_bus !== 8'hFF) begin errors++; $display("FAIL reset bus got %h want FF", o_bus); end
      rst_n = 1'b1;
      exp_rsp_a = 8'h00;
      exp_rsp_b = 8'h00;
   endtask

   task automatic test_write;
      start(1'b0, 1'b1, 3'd3, 8'hA5);
      do_txn("write", 1'b1, 3'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_read;
      start(1'b0, 1'b0, 3'd5, 8'h42);
      do_txn("read", 1'b0, 3'd5, 8'h42, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      repeat (2) @(negedge clk);
      checks++;
      if (o_rd !== 8'h3C) begin
         errors++;
         $display("FAIL read_hold rspData got %h want 3c", o_rd);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] rb;
      rb = 8'($urandom_range(254, 0));
      start(1'b0, 1'b1, 3'd0, 8'h11);
      do_txn("b2b_first", 1'b1, 3'd0, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 8'h07);
      do_txn("b2b_second", 1'b0, 3'd1, 8'h07, rb, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_reset_abort;
      start(1'b0, 1'b1, 3'd2, 8'h5A);
      repeat (2) @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (o_cs !== 1'b0) begin errors++; $display("FAIL abort_strobe cs got %b want 0", o_cs); end
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (o_cs !== 1'b1) begin errors++; $display("FAIL abort cs got %b want 1", o_cs); end
      if (o_we !== 1'b1) begin errors++; $display("FAIL abort we got %b want 1", o_we); end
      if (o_bus !== 8'hFF) begin errors++; $display("FAIL abort bus got %h want FF", o_bus); end
      if (o_ready !== 1'b1) begin errors++; $display("FAIL abort ready got %b want 1", o_ready); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (o_rv !== 1'b0) begin errors++; $display("FAIL abort rspValid got %b want 0", o_rv); end
      end
      rst_n = 1'b1;
      exp_rsp_a = 8'h00;
      exp_rsp_b = 8'h00;
      @(negedge clk);
      checks += 2;
      if (o_rv !== 1'b0) begin errors++; $display("FAIL abort_post rspValid got %b want 0", o_rv); end
      if (o_rd !== 8'h00) begin errors++; $display("FAIL abort_post rspData got %h want 00", o_rd); end
      start(1'b0, 1'b0, 3'd6, 8'h01);
      do_txn("after_abort", 1'b0, 3'd6, 8'h01, 8'hC3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_long_timing;
      logic [2:0] rg;
      logic [7:0] rb, dt;
      rg = 3'($urandom_range(7, 0));
      rb = 8'($urandom_range(254, 0));
      dt = 8'($urandom_range(254, 0));
      start(1'b1, 1'b0, rg, dt);
      do_txn("long_read", 1'b0, rg, dt, rb, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      start(1'b1, 1'b1, rg ^ 3'd5, dt);
      do_txn("long_write", 1'b1, rg ^ 3'd5, dt, rb, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_noise;
      for (int i = 0; i < 6; i++) begin
         bit s, wr;
         logic [2:0] rg;
         logic [7:0] dt, rb;
         s  = 1'($urandom_range(1, 0));
         wr = 1'($urandom_range(1, 0));
         rg = 3'($urandom_range(7, 0));
         dt = 8'($urandom_range(254, 0));
         rb = 8'($urandom_range(254, 0));
         start(s, wr, rg, dt);
         do_txn("noise", wr, rg, dt, rb, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      end
   endtask

   task automatic test_random_chain;
      bit s, wr, nwr;
      logic [2:0] rg, nrg;
      logic [7:0] dt, ndt, rb;
      s  = 1'($urandom_range(1, 0));
      wr = 1'($urandom_range(1, 0));
      rg = 3'($urandom_range(7, 0));
      dt = 8'($urandom_range(254, 0));
      start(s, wr, rg, dt);
      for (int i = 0; i < 8; i++) begin
         nwr = 1'($urandom_range(1, 0));
         nrg = 3'($urandom_range(7, 0));
         ndt = 8'($urandom_range(254, 0));
         rb  = 8'($urandom_range(254, 0));
         do_txn("chain", wr, rg, dt, rb, 1'b0, (i < 7), nwr, nrg, ndt);
         wr = nwr;
         rg = nrg;
         dt = ndt;
      end
   endtask

   initial begin
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_reg   = 3'd0;
      cmd_data  = 8'h00;
      resp_byte = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_abort();
      test_long_timing();
      test_noise();
      test_random_chain();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached got running want finished");
      $fatal(1, "bench timeout");
   end

endmodule
